// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: operation codes, RV32 major opcodes and the
// decoded bundle handed to issue.
package decode_queue_pkg;

    localparam int unsigned OP_LEN = 6;

    // OpWow marks an unsupported encoding; it is also the reset value of dec_op.
    typedef enum logic [OP_LEN-1:0] {
        OpWow,
        OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu,
        OpSb, OpSh, OpSw,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
    } op_e;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic        rd_we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } dec_bundle_t;

    function automatic dec_bundle_t reset_bundle();
        dec_bundle_t b;
        b          = '0;
        b.op       = OpWow;
        return b;
    endfunction

endpackage

// File: rtl/decode_queue_ins_decoder.sv
// Combinational RV32I (+ optional RV32M) decoder: instruction word and PC to a
// decoded bundle. Illegal encodings produce OpWow with all use/write flags cleared.
module decode_queue_ins_decoder import decode_queue_pkg::*; #(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    output dec_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    op_e         op;
    logic [31:0] imm;
    logic        writes, rs1_read, rs2_read, illegal;

    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];
    assign i_imm  = {{20{ins[31]}}, ins[31:20]};
    assign s_imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign b_imm  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign u_imm  = {ins[31:12], 12'h000};
    assign j_imm  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        op       = OpWow;
        imm      = '0;
        writes   = 1'b0;
        rs1_read = 1'b0;
        rs2_read = 1'b0;
        case (opcode)
            OpcLui:   begin op = OpLui;   imm = u_imm; writes = 1'b1; end
            OpcAuipc: begin op = OpAuipc; imm = u_imm; writes = 1'b1; end
            OpcJal:   begin op = OpJal;   imm = j_imm; writes = 1'b1; end
            OpcJalr: begin
                op = OpJalr; imm = i_imm; writes = 1'b1; rs1_read = 1'b1;
            end
            OpcBranch: begin
                imm = b_imm; rs1_read = 1'b1; rs2_read = 1'b1;
                case (funct3)
                    3'b000:  op = OpBeq;
                    3'b001:  op = OpBne;
                    3'b100:  op = OpBlt;
                    3'b101:  op = OpBge;
                    3'b110:  op = OpBltu;
                    3'b111:  op = OpBgeu;
                    default: op = OpWow;
                endcase
            end
            OpcLoad: begin
                imm = i_imm; writes = 1'b1; rs1_read = 1'b1;
                case (funct3)
                    3'b000:  op = OpLb;
                    3'b001:  op = OpLh;
                    3'b010:  op = OpLw;
                    3'b100:  op = OpLbu;
                    3'b101:  op = OpLhu;
                    default: op = OpWow;
                endcase
            end
            OpcStore: begin
                imm = s_imm; rs1_read = 1'b1; rs2_read = 1'b1;
                case (funct3)
                    3'b000:  op = OpSb;
                    3'b001:  op = OpSh;
                    3'b010:  op = OpSw;
                    default: op = OpWow;
                endcase
            end
            OpcOpImm: begin
                imm = i_imm; writes = 1'b1; rs1_read = 1'b1;
                case (funct3)
                    3'b000: op = OpAddi;
                    3'b010: op = OpSlti;
                    3'b011: op = OpSltiu;
                    3'b100: op = OpXori;
                    3'b110: op = OpOri;
                    3'b111: op = OpAndi;
                    3'b001: op = (funct7 == F7Base) ? OpSlli : OpWow;
                    default: begin
                        if (funct7 == F7Base)     op = OpSrli;
                        else if (funct7 == F7Alt) op = OpSrai;
                        else                      op = OpWow;
                    end
                endcase
            end
            OpcOp: begin
                writes = 1'b1; rs1_read = 1'b1; rs2_read = 1'b1;
                case (funct7)
                    F7Base: begin
                        case (funct3)
                            3'b000: op = OpAdd;
                            3'b001: op = OpSll;
                            3'b010: op = OpSlt;
                            3'b011: op = OpSltu;
                            3'b100: op = OpXor;
                            3'b101: op = OpSrl;
                            3'b110: op = OpOr;
                            default: op = OpAnd;
                        endcase
                    end
                    F7Alt: begin
                        if (funct3 == 3'b000)      op = OpSub;
                        else if (funct3 == 3'b101) op = OpSra;
                        else                       op = OpWow;
                    end
                    F7MulDiv: begin
                        if (ENABLE_M) begin
                            case (funct3)
                                3'b000: op = OpMul;
                                3'b001: op = OpMulh;
                                3'b010: op = OpMulhsu;
                                3'b011: op = OpMulhu;
                                3'b100: op = OpDiv;
                                3'b101: op = OpDivu;
                                3'b110: op = OpRem;
                                default: op = OpRemu;
                            endcase
                        end
                    end
                    default: op = OpWow;
                endcase
            end
            default: op = OpWow;
        endcase
    end

    assign illegal = (op == OpWow) || (ins[1:0] != 2'b11);

    always_comb begin
        bundle          = '0;
        bundle.op       = illegal ? OpWow : op;
        bundle.rd       = ins[11:7];
        bundle.rd_we    = writes && !illegal && (ins[11:7] != 5'd0);
        bundle.rs1      = ins[19:15];
        bundle.rs2      = ins[24:20];
        bundle.rs1_used = rs1_read && !illegal;
        bundle.rs2_used = rs2_read && !illegal;
        bundle.imm      = illegal ? 32'h0 : imm;
        bundle.pc       = pc;
        bundle.illegal  = illegal;
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: fetch writes a FIFO, the head entry is decoded into a
// registered bundle and handed to issue over valid/ready. Flush empties everything.
module decode_queue import decode_queue_pkg::*; #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        if_valid,
    input  logic [31:0] if_ins,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        dec_valid,
    input  logic        dec_ready,
    output op_e         dec_op,
    output logic [4:0]  dec_rd,
    output logic        dec_rd_we,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic        dec_rs1_used,
    output logic        dec_rs2_used,
    output logic [31:0] dec_imm,
    output logic [31:0] dec_pc,
    output logic        dec_illegal
);

    localparam int unsigned PtrW = $clog2(IQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     ins_mem [IQ_DEPTH];
    logic [31:0]     pc_mem  [IQ_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    dec_bundle_t     bundle_q, bundle_d, head_bundle;
    logic            enq, load, deq;

    // if_ready looks at count only; a same-cycle dequeue does not free a slot early.
    assign if_ready = (count_q != CntW'(IQ_DEPTH));
    assign enq      = if_valid && if_ready && !flush_in;
    assign load     = (!valid_q || dec_ready) && !flush_in;
    assign deq      = load && (count_q != '0);

    decode_queue_ins_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_ins_decoder (
        .ins    (ins_mem[head_q]),
        .pc     (pc_mem[head_q]),
        .bundle (head_bundle)
    );

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (enq) tail_d = tail_q + PtrW'(1);
            if (deq) begin
                head_d   = head_q + PtrW'(1);
                bundle_d = head_bundle;
                valid_d  = 1'b1;
            end else if (load) begin
                valid_d = 1'b0;
            end
            if (enq && !deq)      count_d = count_q + CntW'(1);
            else if (!enq && deq) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            bundle_q <= reset_bundle();
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            ins_mem[tail_q] <= if_ins;
            pc_mem[tail_q]  <= if_pc;
        end
    end

    assign dec_valid    = valid_q;
    assign dec_op       = bundle_q.op;
    assign dec_rd       = bundle_q.rd;
    assign dec_rd_we    = bundle_q.rd_we;
    assign dec_rs1      = bundle_q.rs1;
    assign dec_rs2      = bundle_q.rs2;
    assign dec_rs1_used = bundle_q.rs1_used;
    assign dec_rs2_used = bundle_q.rs2_used;
    assign dec_imm      = bundle_q.imm;
    assign dec_pc       = bundle_q.pc;
    assign dec_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (M off / M on) driven identically, checked
// every cycle against a queue-based model plus hand-computed literal expectations.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        op_e         op;
        logic [4:0]  rd, rs1, rs2;
        logic        we, u1, u2, ill;
        logic [31:0] imm, pc;
    } exp_t;

    logic        clk_in, rst_in, flush_in, if_valid, dec_ready;
    logic [31:0] if_ins, if_pc;
    logic [1:0]  o_ready, o_valid, o_we, o_u1, o_u2, o_ill;
    op_e         o_op  [2];
    logic [4:0]  o_rd  [2];
    logic [4:0]  o_rs1 [2];
    logic [4:0]  o_rs2 [2];
    logic [31:0] o_imm [2];
    logic [31:0] o_pc  [2];

    int nvec = 0;
    int nerr = 0;
    bit run  = 0;

    decode_queue #(.IQ_DEPTH(DEPTH), .ENABLE_M(1'b0)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .if_valid(if_valid),
        .if_ins(if_ins), .if_pc(if_pc), .if_ready(o_ready[0]), .dec_valid(o_valid[0]),
        .dec_ready(dec_ready), .dec_op(o_op[0]), .dec_rd(o_rd[0]), .dec_rd_we(o_we[0]),
        .dec_rs1(o_rs1[0]), .dec_rs2(o_rs2[0]), .dec_rs1_used(o_u1[0]),
        .dec_rs2_used(o_u2[0]), .dec_imm(o_imm[0]), .dec_pc(o_pc[0]),
        .dec_illegal(o_ill[0])
    );

    decode_queue #(.IQ_DEPTH(DEPTH), .ENABLE_M(1'b1)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .if_valid(if_valid),
        .if_ins(if_ins), .if_pc(if_pc), .if_ready(o_ready[1]), .dec_valid(o_valid[1]),
        .dec_ready(dec_ready), .dec_op(o_op[1]), .dec_rd(o_rd[1]), .dec_rd_we(o_we[1]),
        .dec_rs1(o_rs1[1]), .dec_rs2(o_rs2[1]), .dec_rs1_used(o_u1[1]),
        .dec_rs2_used(o_u2[1]), .dec_imm(o_imm[1]), .dec_pc(o_pc[1]),
        .dec_illegal(o_ill[1])
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode built from lookup tables keyed by funct3.
    function automatic exp_t md(input logic [31:0] ins, input logic [31:0] pc, input bit em);
        exp_t e;
        op_e br[8], ld[8], st[8], oi[8], r0[8], r1[8], rm[8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic wr, u1, u2;
        br = '{OpBeq, OpBne, OpWow, OpWow, OpBlt, OpBge, OpBltu, OpBgeu};
        ld = '{OpLb, OpLh, OpLw, OpWow, OpLbu, OpLhu, OpWow, OpWow};
        st = '{OpSb, OpSh, OpSw, OpWow, OpWow, OpWow, OpWow, OpWow};
        oi = '{OpAddi, OpSlli, OpSlti, OpSltiu, OpXori, OpSrli, OpOri, OpAndi};
        r0 = '{OpAdd, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd};
        r1 = '{OpSub, OpWow, OpWow, OpWow, OpWow, OpSra, OpWow, OpWow};
        rm = '{OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.pc = pc;
        e.op = OpWow; e.imm = 32'h0; wr = 0; u1 = 0; u2 = 0;
        case (ins[6:0])
            7'h37: begin e.op = OpLui;   e.imm = {ins[31:12], 12'h000}; wr = 1; end
            7'h17: begin e.op = OpAuipc; e.imm = {ins[31:12], 12'h000}; wr = 1; end
            7'h6f: begin
                e.op = OpJal; wr = 1;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin e.op = OpJalr; e.imm = 32'($signed(ins[31:20])); wr = 1; u1 = 1; end
            7'h63: begin
                e.op = br[f3]; u1 = 1; u2 = 1;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h03: begin e.op = ld[f3]; e.imm = 32'($signed(ins[31:20])); wr = 1; u1 = 1; end
            7'h23: begin
                e.op = st[f3]; u1 = 1; u2 = 1;
                e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'h13: begin
                e.op = oi[f3];
                if (f3 == 3'd1 && f7 != 7'h00) e.op = OpWow;
                if (f3 == 3'd5) e.op = (f7 == 7'h00) ? OpSrli : (f7 == 7'h20) ? OpSrai : OpWow;
                e.imm = 32'($signed(ins[31:20])); wr = 1; u1 = 1;
            end
            7'h33: begin
                e.op = (f7 == 7'h00) ? r0[f3] : (f7 == 7'h20) ? r1[f3] :
                       (f7 == 7'h01 && em) ? rm[f3] : OpWow;
                wr = 1; u1 = 1; u2 = 1;
            end
            default: e.op = OpWow;
        endcase
        e.ill = (e.op == OpWow);
        if (e.ill) begin e.imm = 32'h0; wr = 0; u1 = 0; u2 = 0; end
        e.we = wr && (e.rd != 5'd0);
        e.u1 = u1;
        e.u2 = u2;
        return e;
    endfunction

    // Model: queue of {ins, pc} plus one output slot per ENABLE_M setting.
    logic [63:0] mq[$];
    logic [63:0] m_head;
    bit          mv;
    bit          m_room;
    exp_t        mb[2];

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in || flush_in) begin
            mq.delete();
            mv = 0;
        end else begin
            m_room = (mq.size() < DEPTH);
            if (!mv || dec_ready) begin
                if (mq.size() > 0) begin
                    m_head = mq.pop_front();
                    mb[0]  = md(m_head[63:32], m_head[31:0], 1'b0);
                    mb[1]  = md(m_head[63:32], m_head[31:0], 1'b1);
                    mv     = 1;
                end else begin
                    mv = 0;
                end
            end
            if (if_valid && m_room) mq.push_back({if_ins, if_pc});
        end
    end

    task automatic cmp(input int k);
        exp_t e;
        chk($sformatf("dut%0d if_ready", k), o_ready[k], (mq.size() < DEPTH));
        chk($sformatf("dut%0d dec_valid", k), o_valid[k], mv);
        if (mv) begin
            e = mb[k];
            chk($sformatf("dut%0d op pc=%0h", k, e.pc), o_op[k], e.op);
            chk($sformatf("dut%0d illegal pc=%0h", k, e.pc), o_ill[k], e.ill);
            chk($sformatf("dut%0d rd_we pc=%0h", k, e.pc), o_we[k], e.we);
            chk($sformatf("dut%0d rs1_used pc=%0h", k, e.pc), o_u1[k], e.u1);
            chk($sformatf("dut%0d rs2_used pc=%0h", k, e.pc), o_u2[k], e.u2);
            chk($sformatf("dut%0d imm pc=%0h", k, e.pc), o_imm[k], e.imm);
            chk($sformatf("dut%0d pc", k), o_pc[k], e.pc);
            if (!e.ill) begin
                chk($sformatf("dut%0d rd pc=%0h", k, e.pc), o_rd[k], e.rd);
                chk($sformatf("dut%0d rs1 pc=%0h", k, e.pc), o_rs1[k], e.rs1);
                chk($sformatf("dut%0d rs2 pc=%0h", k, e.pc), o_rs2[k], e.rs2);
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (run) begin
            cmp(0);
            cmp(1);
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        if_valid = v; if_ins = ins; if_pc = pc; dec_ready = rdy; flush_in = fl;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s dut%0d valid", tag, k), o_valid[k], 1'b0);
            chk($sformatf("%s dut%0d op", tag, k), o_op[k], OpWow);
            chk($sformatf("%s dut%0d illegal", tag, k), o_ill[k], 1'b0);
            chk($sformatf("%s dut%0d rd_we", tag, k), o_we[k], 1'b0);
            chk($sformatf("%s dut%0d used", tag, k), {o_u1[k], o_u2[k]}, 2'b00);
            chk($sformatf("%s dut%0d regs", tag, k), {o_rd[k], o_rs1[k], o_rs2[k]}, 15'h0);
            chk($sformatf("%s dut%0d imm", tag, k), o_imm[k], 32'h0);
            chk($sformatf("%s dut%0d pc", tag, k), o_pc[k], 32'h0);
        end
    endtask

    logic [31:0] vecs [16];
    exp_t        pin;

    initial begin
        vecs = '{32'h123450B7, 32'hFFFFF117, 32'h008000EF, 32'h000080E7,
                 32'h0040A103, 32'h0020A223, 32'h4020D093, 32'h0200D093,
                 32'h402081B3, 32'h0220D1B3, 32'h00002063, 32'h0000B023,
                 32'h00003083, 32'h40001033, 32'h00000000, 32'h0000007F};

        // Pin the model against hand-decoded words.
        pin = md(32'h00500093, 32'h0, 1'b0);
        chk("model addi op", pin.op, OpAddi);
        chk("model addi imm", pin.imm, 32'h5);
        pin = md(32'hFE000EE3, 32'h0, 1'b0);
        chk("model beq imm", pin.imm, 32'hFFFFFFFC);
        pin = md(32'h02208033, 32'h0, 1'b1);
        chk("model mul op", pin.op, OpMul);
        pin = md(32'h02208033, 32'h0, 1'b0);
        chk("model mul illegal", pin.ill, 1'b1);

        rst_in = 1'b0;
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk_reset_vals("reset");
        rst_in = 1'b1;
        run    = 1;
        chk("reset if_ready", o_ready[0], 1'b1);

        // ADDI x1,x0,5: visible one edge after the enqueue edge.
        step(1, 32'h00500093, 32'h0, 1, 0);
        chk("addi latency valid", o_valid[0], 1'b0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("addi valid", o_valid[0], 1'b1);
        chk("addi op", o_op[0], OpAddi);
        chk("addi rd", o_rd[0], 5'd1);
        chk("addi rd_we", o_we[0], 1'b1);
        chk("addi imm", o_imm[0], 32'h5);
        chk("addi used", {o_u1[0], o_u2[0]}, 2'b10);
        step(0, 32'h0, 32'h0, 1, 0);

        // BEQ x0,x0,-4
        step(1, 32'hFE000EE3, 32'h100, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("beq op", o_op[0], OpBeq);
        chk("beq imm", o_imm[0], 32'hFFFFFFFC);
        chk("beq rd_we", o_we[0], 1'b0);
        chk("beq used", {o_u1[0], o_u2[0]}, 2'b11);

        // MUL x0,x1,x2 on both instances
        step(1, 32'h02208033, 32'h104, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("mul m1 op", o_op[1], OpMul);
        chk("mul m1 rd_we", o_we[1], 1'b0);
        chk("mul m1 illegal", o_ill[1], 1'b0);
        chk("mul m0 op", o_op[0], OpWow);
        chk("mul m0 illegal", o_ill[0], 1'b1);
        step(0, 32'h0, 32'h0, 1, 0);

        // Fill with issue stalled; nine accepted (one sits in the output register).
        for (int i = 0; i < 10; i++) begin
            step(1, {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'h13}, 32'(4 * i), 0, 0);
            chk($sformatf("fill if_ready i=%0d", i), o_ready[0], (i < 8));
        end
        chk("fill held pc", o_pc[0], 32'h0);
        for (int j = 1; j <= 9; j++) begin
            step(0, 32'h0, 32'h0, 1, 0);
            chk($sformatf("drain valid j=%0d", j), o_valid[0], (j <= 8));
            if (j <= 8) chk($sformatf("drain pc j=%0d", j), o_pc[0], 32'(4 * j));
        end

        // Flush with five queued entries and a same-cycle enqueue.
        for (int i = 0; i < 6; i++) step(1, 32'h00100093, 32'h300 + 32'(4 * i), 0, 0);
        chk("preflush valid", o_valid[0], 1'b1);
        step(1, 32'h00200113, 32'h400, 1, 1);
        chk("flush valid", o_valid[0], 1'b0);
        chk("flush if_ready", o_ready[0], 1'b1);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("postflush valid a", o_valid[0], 1'b0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("postflush valid b", o_valid[0], 1'b0);

        // Mixed legal/illegal stream, back-to-back then with intermittent stalls.
        for (int i = 0; i < 16; i++) step(1, vecs[i], 32'h1000 + 32'(4 * i), 1, 0);
        for (int i = 0; i < 16; i++)
            step(1, vecs[15 - i], 32'h2000 + 32'(4 * i), (i % 3) != 0, 0);
        for (int i = 0; i < 12; i++) step(0, 32'h0, 32'h0, (i % 2) == 0, 0);

        // Asynchronous reset while a bundle is held.
        step(1, 32'h00500093, 32'h500, 0, 0);
        step(1, 32'h00600093, 32'h504, 0, 0);
        chk("prereset valid", o_valid[1], 1'b1);
        #2;
        rst_in = 1'b0;
        #1;
        chk_reset_vals("async reset");
        step(0, 32'h0, 32'h0, 1, 0);
        rst_in = 1'b1;
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("after reset valid", o_valid[0], 1'b0);
        chk("after reset if_ready", o_ready[0], 1'b1);

        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised decode stage between instruction fetch and issue. Accepts raw 32-bit instructions with their PCs into a DEPTH-entry FIFO, decodes the head entry each cycle into a registered bundle, and hands it to issue over a valid/ready handshake. Over the previous purely combinational decoder it adds buffering, flush, optional M-extension decode, explicit illegal-instruction reporting and register-use/write-enable flags.

## Interface
- IQ_DEPTH, 8, FIFO entries; power of two, ≥2
- ENABLE_M, 0, 1 = decode RV32M (MUL..REMU); 0 = those encodings are illegal
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  reset; asynchronous, active-low
- flush_in  input  1  branch mispredict / exception flush
- if_valid  input  1  fetch presents an instruction
- if_ins  input  32  instruction word
- if_pc  input  32  instruction PC
- if_ready  output  1  FIFO can accept (count < IQ_DEPTH)
- dec_valid  output  1  decoded bundle valid
- dec_ready  input  1  issue accepts (driven by issue when ROB and RS both have a free slot)
- dec_op  output  `OP_LEN  operation code
- dec_rd  output  5  destination register
- dec_rd_we  output  1  writes rd (rd≠0 and type writes)
- dec_rs1 / dec_rs2  output  5 each  source registers (ins[19:15] / ins[24:20])
- dec_rs1_used / dec_rs2_used  output  1 each  source is read
- dec_imm  output  32  sign-extended immediate (0 for R-type)
- dec_pc  output  32  instruction PC
- dec_illegal  output  1  encoding not supported; dec_op = `WOW

## Operation
- Enqueue on edge when if_valid && if_ready && !flush_in; write at tail, tail++ mod IQ_DEPTH.
- Output register load condition: (!dec_valid || dec_ready) && count≠0 && !flush_in → load decode of head, head++, dec_valid=1. If condition holds with count=0 → dec_valid=0.
- Enqueue and dequeue in same cycle: count unchanged. if_ready depends only on count (no look-ahead for same-cycle dequeue).
- flush_in: highest priority; head=tail=count=0, dec_valid=0; same-cycle if_valid and dec_ready ignored.
- Decode: LUI/AUIPC U-imm; JAL J-imm (rd only); JALR I-imm, rs1; branches B-imm, rs1+rs2, rd_we=0; loads LB/LH/LW/LBU/LHU I-imm, rs1; stores SB/SH/SW S-imm, rs1+rs2, rd_we=0; OP-IMM I-imm, rs1; OP rs1+rs2, funct7 0000000/0100000 (SUB/SRA only with 0100000), 0000001 → M ops when ENABLE_M.
- Illegal: ins[1:0]≠11; unknown opcode; branch func3 010/011; load func3 011/110/111; store func3 ≥011; shift-imm with ins[31:25] not 0000000 (or 0100000 for SRAI); bad funct7; M encodings with ENABLE_M=0. Illegal bundles still flow (dec_valid=1, dec_illegal=1, all use/we flags 0) so the ROB can raise an exception in order.

## Timing
- Reset (rst_in low, immediate): head=tail=count=0; dec_valid=0, dec_illegal=0, dec_rd_we=0, dec_rs1_used=dec_rs2_used=0, dec_op=`WOW, dec_rd/rs1/rs2=0, dec_imm=0, dec_pc=0; if_ready=1 after release.
- Latency: instruction enqueued at edge t is on dec_* after edge t+1 (empty FIFO, output free). No combinational path if_* → dec_*.
- Bundle holds stable while dec_valid && !dec_ready.
- Throughput 1/cycle sustained when dec_ready stays high.
- Full: count=IQ_DEPTH → if_ready=0; pointer wrap by modulo with log2(IQ_DEPTH) bits, count has one extra bit.

## Structure
- def.v: `OP_LEN, all op codes incl. new `MUL,`MULH,`MULHSU,`MULHU,`DIV,`DIVU,`REM,`REMU, `WOW as illegal op; opcode constants.
- Sub-module ins_decoder: purely combinational ins/pc → bundle fields, parameter ENABLE_M; decode_queue holds FIFO, output register, control.

## Test plan
- Reset then enqueue 0x00500093 (ADDI x1,x0,5) pc 0x0 → next cycle dec_op=`ADDI, rd=1, rd_we=1, imm=5, rs1_used=1, rs2_used=0.
- dec_ready=0, enqueue IQ_DEPTH instructions → if_ready=0 after count reaches IQ_DEPTH; release dec_ready → all emerge in order, PCs 0x0,0x4,… incl. wrap.
- Enqueue 0xFE000EE3 (BEQ x0,x0,-4) → op=`BEQ, imm=0xFFFFFFFC, rd_we=0, rs1/rs2_used=1.
- 0x02208033 (MUL x0,x1,x2): ENABLE_M=1 → op=`MUL, rd_we=0 (rd=0); ENABLE_M=0 → dec_illegal=1, op=`WOW.
- Queue holding 5 entries, dec_valid=1, assert flush_in with if_valid=1 → next cycle dec_valid=0, count=0, flushed-cycle instruction not enqueued.
- Drop rst_in mid-stream with dec_valid=1 → outputs reach reset values immediately, before next clock edge.
